// File: rtl/assoc_cache_ctrl.sv
// -----------------------------------------------------------------------------
// assoc_cache_ctrl
//
// N-way set-associative, write-back, write-allocate cache controller sitting
// between a byte-wide CPU port and a line-wide main-memory port. Tags, valid
// bits, dirty bits, round-robin victim pointers and line data are held in
// flops inside this module.
//
// Miss path: LOOKUP picks a victim (lowest invalid way, else the set's
// round-robin pointer). A dirty victim is written back first, then the line is
// refilled. The original request is then replayed through LOOKUP, where it is
// guaranteed to hit; the replay is not counted as a hit or as a second miss.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   cpu_req_valid/_ready    CPU request handshake (ready only in IDLE)
//   cpu_req_write           1 = byte write, 0 = byte read
//   cpu_addr, cpu_wdata     byte address and write byte
//   cpu_rdata, cpu_rvalid   read byte and one-cycle read-completion pulse
//   cpu_wdone               one-cycle write-completion pulse
//   mem_req_valid/_ready    memory request handshake
//   mem_req_write           1 = line writeback, 0 = line read
//   mem_addr, mem_wdata     line-aligned address and writeback line
//   mem_rvalid, mem_rdata   refill line return
//   hit_count, miss_count   saturating 16-bit event counters
// -----------------------------------------------------------------------------
module assoc_cache_ctrl #(
    parameter int AWIDTH    = 16,
    parameter int DATAWIDTH = 8,
    parameter int BLOCKSIZE = 4,
    parameter int NUMSETS   = 8,
    parameter int NUMWAYS   = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cpu_req_valid,
    input  logic                           cpu_req_write,
    input  logic [AWIDTH-1:0]              cpu_addr,
    input  logic [DATAWIDTH-1:0]           cpu_wdata,
    output logic                           cpu_req_ready,
    output logic [DATAWIDTH-1:0]           cpu_rdata,
    output logic                           cpu_rvalid,
    output logic                           cpu_wdone,
    output logic                           mem_req_valid,
    output logic                           mem_req_write,
    output logic [AWIDTH-1:0]              mem_addr,
    output logic [DATAWIDTH*BLOCKSIZE-1:0] mem_wdata,
    input  logic                           mem_req_ready,
    input  logic                           mem_rvalid,
    input  logic [DATAWIDTH*BLOCKSIZE-1:0] mem_rdata,
    output logic [15:0]                    hit_count,
    output logic [15:0]                    miss_count
);

    localparam int OFFW   = $clog2(BLOCKSIZE);
    localparam int IDXW   = $clog2(NUMSETS);
    localparam int TAGW   = AWIDTH - IDXW - OFFW;
    localparam int LINEW  = DATAWIDTH * BLOCKSIZE;
    localparam int DWLOG  = $clog2(DATAWIDTH);
    localparam int BITW   = OFFW + DWLOG;
    localparam int WAYW   = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOOKUP      = 3'd1,
        S_WRITEBACK   = 3'd2,
        S_REFILL      = 3'd3,
        S_REFILL_WAIT = 3'd4
    } state_t;

    // Cache state arrays
    logic [TAGW-1:0]    r_tag   [NUMWAYS][NUMSETS];
    logic [LINEW-1:0]   r_data  [NUMWAYS][NUMSETS];
    logic [NUMSETS-1:0] r_valid [NUMWAYS];
    logic [NUMSETS-1:0] r_dirty [NUMWAYS];
    logic [WAYW-1:0]    r_ptr   [NUMSETS];

    // Controller state and latched request
    state_t                r_state;
    logic [AWIDTH-1:0]     r_addr;
    logic                  r_write;
    logic [DATAWIDTH-1:0]  r_wdata;
    logic [WAYW-1:0]       r_victim;
    logic                  r_replay;

    // Decoded fields of the latched request
    logic [TAGW-1:0]       w_tag;
    logic [IDXW-1:0]       w_idx;
    logic [OFFW-1:0]       w_off;
    logic [BITW-1:0]       w_bitpos;

    assign w_tag    = r_addr[AWIDTH-1 -: TAGW];
    assign w_idx    = r_addr[OFFW +: IDXW];
    assign w_off    = r_addr[OFFW-1:0];
    assign w_bitpos = {w_off, {DWLOG{1'b0}}};

    // Lookup results
    logic                  w_hit;
    logic [WAYW-1:0]       w_hit_way;
    logic [WAYW-1:0]       w_victim_raw;
    logic [WAYW-1:0]       w_victim;
    logic [LINEW-1:0]      w_sel_line;
    logic [LINEW-1:0]      w_merge_line;
    logic [DATAWIDTH-1:0]  w_rbyte;
    logic [AWIDTH-1:0]     w_refill_addr;

    // Tag compare across all ways and victim choice for the indexed set
    always_comb begin
        w_hit        = 1'b0;
        w_hit_way    = '0;
        w_victim_raw = r_ptr[w_idx];
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = NUMWAYS - 1; w >= 0; w--) begin
            w_hit        = (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) ? 1'b1 : w_hit;
            w_hit_way    = (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) ? WAYW'(w) : w_hit_way;
            w_victim_raw = (!r_valid[w][w_idx]) ? WAYW'(w) : w_victim_raw;
        end
        // A direct-mapped cache always replaces its only way.
        w_victim = (NUMWAYS == 1) ? '0 : w_victim_raw;
    end

    // Byte read / byte merge on the hit line
    always_comb begin
        w_sel_line                             = r_data[w_hit_way][w_idx];
        w_rbyte                                = w_sel_line[w_bitpos +: DATAWIDTH];
        w_merge_line                           = w_sel_line;
        w_merge_line[w_bitpos +: DATAWIDTH]    = r_wdata;
        w_refill_addr                          = {w_tag, w_idx, {OFFW{1'b0}}};
    end

    // Controller FSM, cache arrays and all registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_victim      <= '0;
            r_replay      <= 1'b0;
            cpu_req_ready <= 1'b1;
            cpu_rdata     <= '0;
            cpu_rvalid    <= 1'b0;
            cpu_wdone     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            hit_count     <= 16'd0;
            miss_count    <= 16'd0;
            for (int w = 0; w < NUMWAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
            for (int s = 0; s < NUMSETS; s++) begin
                r_ptr[s] <= '0;
            end
        end else begin
            // Completion strobes are single-cycle pulses.
            cpu_rvalid <= 1'b0;
            cpu_wdone  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_valid && cpu_req_ready) begin
                        r_addr        <= cpu_addr;
                        r_write       <= cpu_req_write;
                        r_wdata       <= cpu_wdata;
                        r_replay      <= 1'b0;
                        cpu_req_ready <= 1'b0;
                        r_state       <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_write) begin
                            r_data[w_hit_way][w_idx]  <= w_merge_line;
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                            cpu_wdone                 <= 1'b1;
                        end else begin
                            cpu_rdata  <= w_rbyte;
                            cpu_rvalid <= 1'b1;
                        end
                        // The replay after a refill was already counted as a miss.
                        if (!r_replay && (hit_count != 16'hFFFF)) begin
                            hit_count <= hit_count + 16'd1;
                        end
                        r_replay      <= 1'b0;
                        cpu_req_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        if (!r_replay && (miss_count != 16'hFFFF)) begin
                            miss_count <= miss_count + 16'd1;
                        end
                        r_victim      <= w_victim;
                        mem_req_valid <= 1'b1;
                        if (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) begin
                            mem_req_write <= 1'b1;
                            mem_addr      <= {r_tag[w_victim][w_idx], w_idx, {OFFW{1'b0}}};
                            mem_wdata     <= r_data[w_victim][w_idx];
                            r_state       <= S_WRITEBACK;
                        end else begin
                            mem_req_write <= 1'b0;
                            mem_addr      <= w_refill_addr;
                            r_state       <= S_REFILL;
                        end
                    end
                end

                S_WRITEBACK: begin
                    // Writeback accepted: turn the request straight into the line read.
                    if (mem_req_ready) begin
                        mem_req_write <= 1'b0;
                        mem_addr      <= w_refill_addr;
                        r_state       <= S_REFILL;
                    end
                end

                S_REFILL: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= S_REFILL_WAIT;
                    end
                end

                S_REFILL_WAIT: begin
                    if (mem_rvalid) begin
                        r_data[r_victim][w_idx]  <= mem_rdata;
                        r_tag[r_victim][w_idx]   <= w_tag;
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                        // Only replacing a live line moves the round-robin pointer.
                        if ((NUMWAYS > 1) && r_valid[r_victim][w_idx]) begin
                            r_ptr[w_idx] <= r_ptr[w_idx] + WAYW'(1);
                        end
                        r_replay <= 1'b1;
                        r_state  <= S_LOOKUP;
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    cpu_req_ready <= 1'b1;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache controller between a byte-wide CPU port and a line-wide main-memory port. It generalises the existing 2-way controller to configurable ways, sets and line size, and completes the miss path: dirty-victim writeback, line refill and request replay. The tag, valid and dirty state and the data arrays are held internally in flops. Separate unidirectional CPU and memory buses with valid/ready handshakes replace the inout buses.

Parameters:
AWIDTH, 16, byte address width
DATAWIDTH, 8, CPU data width in bits (one byte)
BLOCKSIZE, 4, bytes per line (power of 2, at least 2)
NUMSETS, 8, number of sets (power of 2, at least 2)
NUMWAYS, 2, associativity (power of 2, 1 to 8)
Derived: OFFW=log2(BLOCKSIZE), IDXW=log2(NUMSETS), TAGW=AWIDTH-IDXW-OFFW, LINEW=DATAWIDTH*BLOCKSIZE

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cpu_req_valid  in  1  CPU request present
cpu_req_write  in  1  1=write, 0=read
cpu_addr  in  AWIDTH  byte address
cpu_wdata  in  DATAWIDTH  write byte
cpu_req_ready  out  1  controller can accept a request
cpu_rdata  out  DATAWIDTH  read byte, valid while cpu_rvalid=1
cpu_rvalid  out  1  one-cycle read-completion pulse
cpu_wdone  out  1  one-cycle write-completion pulse
mem_req_valid  out  1  memory request present
mem_req_write  out  1  1=line writeback, 0=line read
mem_addr  out  AWIDTH  line-aligned address (low OFFW bits = 0)
mem_wdata  out  LINEW  writeback line; byte k at bits [8k+7:8k]
mem_req_ready  in  1  memory accepts the request
mem_rvalid  in  1  refill data valid
mem_rdata  in  LINEW  refill line
hit_count  out  16  saturating hit counter
miss_count  out  16  saturating miss counter

Behaviour:
- Reset (checked at the clock edge) returns state to IDLE and clears every valid bit, dirty bit, per-set victim pointer and counter.
- Reset drives all outputs to 0, except cpu_req_ready=1 in IDLE. Data and tag arrays are not cleared.
- Address split: tag=addr[AWIDTH-1:IDXW+OFFW], index=addr[IDXW+OFFW-1:OFFW], offset=addr[OFFW-1:0].
- A request is accepted on an edge where cpu_req_valid and cpu_req_ready are both 1. addr, write flag and wdata are latched. cpu_req_ready=1 only in IDLE.
- IDLE -> LOOKUP on acceptance.
- LOOKUP, hit (valid and tag match in exactly one way):
  - Read: cpu_rdata=selected byte, cpu_rvalid=1 for the next cycle.
  - Write: merge the byte into the line, set dirty, cpu_wdone=1 for the next cycle.
  - hit_count++. Go to IDLE.
  - Hit latency is 2 edges from acceptance to the completion pulse.
- LOOKUP, miss: miss_count++, choose a victim.
  - Victim = lowest-index invalid way; if none, the set's round-robin pointer.
  - Victim valid and dirty -> WRITEBACK, else -> REFILL.
  - A replayed lookup after refill does not count as a second miss or as a hit.
- WRITEBACK:
  - mem_req_valid=1, mem_req_write=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line.
  - All held stable until mem_req_ready=1, then -> REFILL.
- REFILL:
  - mem_req_valid=1, mem_req_write=0, mem_addr={latched tag, index, 0}.
  - Held until mem_req_ready=1, then -> REFILL_WAIT.
- REFILL_WAIT:
  - On mem_rvalid: write mem_rdata into the victim way, tag=latched tag, valid=1, dirty=0.
  - If the victim was previously valid, advance that set's pointer modulo NUMWAYS. Filling an invalid way leaves the pointer unchanged.
  - -> LOOKUP (replay, guaranteed hit).
- mem_rvalid outside REFILL_WAIT is ignored. mem_req_valid is deasserted on the edge the handshake completes.
- cpu_req_valid while not in IDLE is not accepted and has no side effects.
- Counters saturate at 16'hFFFF.
- Reset mid-operation abandons any outstanding memory transaction: mem_req_valid=0 from the next cycle and no array update. Later lookups miss because all lines are invalid.
- NUMWAYS=1 degenerates to direct-mapped; the pointer is unused.

Test Plan:
- Defaults. Cold read 0x0124, memory returns 32'hDDCCBBAA -> mem read at 0x0124, cpu_rdata=8'hAA, miss_count=1. Then read 0x0126 -> rvalid 2 edges after acceptance, rdata=8'hCC, hit_count=1, no memory request.
- Write 0x0125=8'h5A after the fill -> cpu_wdone pulse, no memory traffic. A subsequent read of 0x0125 returns 8'h5A.
- Fill 0x0224 into way1 (set 1). Then read 0x0324 -> writeback mem_addr=0x0124, mem_wdata=32'hDDCC5AAA, refill from 0x0324. Set-1 pointer becomes 1; the next conflicting miss evicts way1 without writeback (clean).
- Hold mem_req_ready=0 for 5 cycles during WRITEBACK and REFILL -> mem_req_valid, mem_addr and mem_wdata stable, cpu_req_ready=0, cpu_req_valid pulses ignored.
- Assert reset for one cycle in REFILL_WAIT -> mem_req_valid=0 next cycle, counters=0, a late mem_rvalid is ignored, and a read of 0x0124 misses again.
- NUMWAYS=4, NUMSETS=4, BLOCKSIZE=8 -> five conflicting addresses in one set: first four fill ways 0-3 with no eviction, fifth evicts way0, miss_count=5.
